// File: rtl/serial_pkg.sv
// Shared types and constants for the serial link: FSM state encoding and
// SC register bit positions.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SHIFT_HI = 2'd1,
    SHIFT_LO = 2'd2
  } state_t;

  localparam int SC_START  = 7;
  localparam int SC_CLKSEL = 0;

  // Unimplemented SC bits read back as ones.
  localparam logic [5:0] SC_UNUSED = 6'h3F;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous input bit.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk1,
  input  logic nreset2,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state always uses non-blocking assignments so every
  // flop samples the pre-edge value of its neighbours.
  always_ff @(posedge clk1 or negedge nreset2) begin
    if (!nreset2) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/serial_link.sv
// Serial link: SB data register, SC control register, and an 8-bit shifter
// clocked either by the internal tick or by an external serial clock.
module serial_link
  import serial_pkg::*;
(
  input  logic       clk1,
  input  logic       nreset2,
  input  logic       ff01,
  input  logic       ff02,
  input  logic       cpu_wr,
  input  logic       cpu_rd,
  input  logic [7:0] d_in,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic       tick_8192hz,
  input  logic       sck_in,
  input  logic       sin,
  output logic       sck_out,
  output logic       sck_oe,
  output logic       sout,
  output logic       int_serial
);

  state_t     state, state_next;
  logic [7:0] sb, sb_next;
  logic       start, start_next;
  logic       clk_sel, clk_sel_next;
  logic [2:0] cnt, cnt_next;
  logic       sck_out_next;
  logic       sout_next;
  logic       int_next;

  logic       sck_sync, sin_sync, sck_prev;
  logic       fall_edge, rise_edge;
  logic       wr_sb, wr_sc;

  sync2 #(.RESET_VAL(1'b1)) u_sync_sck (
    .clk1    (clk1),
    .nreset2 (nreset2),
    .d       (sck_in),
    .q       (sck_sync)
  );

  sync2 #(.RESET_VAL(1'b1)) u_sync_sin (
    .clk1    (clk1),
    .nreset2 (nreset2),
    .d       (sin),
    .q       (sin_sync)
  );

  always_ff @(posedge clk1 or negedge nreset2) begin
    if (!nreset2) sck_prev <= 1'b1;
    else          sck_prev <= sck_sync;
  end

  // In internal mode the FSM state decides whether a tick is a falling or a
  // rising edge, so the same tick feeds both.
  assign fall_edge = clk_sel ? tick_8192hz : (sck_prev & ~sck_sync);
  assign rise_edge = clk_sel ? tick_8192hz : (~sck_prev & sck_sync);

  assign wr_sb = cpu_wr & ff01;
  assign wr_sc = cpu_wr & ff02;

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    sb_next      = sb;
    start_next   = start;
    clk_sel_next = clk_sel;
    cnt_next     = cnt;
    sck_out_next = sck_out;
    sout_next    = sout;
    int_next     = 1'b0;

    case (state)
      SHIFT_HI: begin
        if (fall_edge) begin
          state_next = SHIFT_LO;
          sout_next  = sb[7];
          if (clk_sel) sck_out_next = 1'b0;
        end
      end
      SHIFT_LO: begin
        if (rise_edge) begin
          sb_next  = {sb[6:0], sin_sync};
          cnt_next = cnt + 3'd1;
          if (clk_sel) sck_out_next = 1'b1;
          if (cnt == 3'd7) begin
            start_next = 1'b0;
            state_next = IDLE;
            int_next   = 1'b1;
          end else begin
            state_next = SHIFT_HI;
          end
        end
      end
      default: ;
    endcase

    // CPU data write wins over the shift; the count and completion still run.
    if (wr_sb) sb_next = d_in;

    // A control write restarts or aborts, and ignores any coincident edge.
    if (wr_sc) begin
      start_next   = d_in[SC_START];
      clk_sel_next = d_in[SC_CLKSEL];
      cnt_next     = 3'd0;
      sck_out_next = 1'b1;
      int_next     = 1'b0;
      state_next   = d_in[SC_START] ? SHIFT_HI : IDLE;
    end
  end

  always_ff @(posedge clk1 or negedge nreset2) begin
    if (!nreset2) begin
      state      <= IDLE;
      sb         <= 8'h00;
      start      <= 1'b0;
      clk_sel    <= 1'b0;
      cnt        <= 3'd0;
      sck_out    <= 1'b1;
      sout       <= 1'b1;
      int_serial <= 1'b0;
    end else begin
      state      <= state_next;
      sb         <= sb_next;
      start      <= start_next;
      clk_sel    <= clk_sel_next;
      cnt        <= cnt_next;
      sck_out    <= sck_out_next;
      sout       <= sout_next;
      int_serial <= int_next;
    end
  end

  assign sck_oe = clk_sel;
  assign d_oe   = cpu_rd & (ff01 | ff02);

  always_comb begin
    d_out = 8'hFF;
    if (d_oe) begin
      if (ff01) d_out = sb;
      else      d_out = {start, SC_UNUSED, clk_sel};
    end
  end

endmodule

// File: doc/serial_link.md
SERIAL_LINK -- requirements
Module: serial_link

Interface
REQ-001 SHALL have port clk1  in  1  single system clock; all state updates on its rising edge.
REQ-002 SHALL have port nreset2  in  1  reset, asynchronous and active-low.
REQ-003 SHALL have port ff01  in  1  SB register select, from the address decoder.
REQ-004 SHALL have port ff02  in  1  SC register select.
REQ-005 SHALL have port cpu_wr  in  1  write strobe, one clk1 cycle wide.
REQ-006 SHALL have port cpu_rd  in  1  read strobe.
REQ-007 SHALL have port d_in  in  8  CPU write data.
REQ-008 SHALL have ports d_out  out  8  read data, and d_oe  out  1  read-data enable.
REQ-009 SHALL have port tick_8192hz  in  1  one-clk1-cycle enable pulse from the divider.
REQ-010 SHALL have ports sck_in  in  1  external serial clock, and sin  in  1  serial data in.
REQ-011 SHALL have ports sck_out  out  1  internal serial clock, sck_oe  out  1  drive enable for sck_out, and sout  out  1  serial data out.
REQ-012 SHALL have port int_serial  out  1  transfer-complete pulse to the interrupt block.

Function
REQ-013 SHALL hold SB[7:0] and SC = {start, clk_sel}, where start is bit 7 and clk_sel is bit 0.
REQ-014 Reads SHALL be combinational:
- d_oe = cpu_rd & (ff01 | ff02).
- FF01 reads return SB.
- FF02 reads return {start, 6'b111111, clk_sel}.
- d_out SHALL be 8'hFF when d_oe=0.
REQ-015 A cpu_wr to FF02 SHALL load start=d_in[7] and clk_sel=d_in[0].
REQ-016 A cpu_wr to FF02 with d_in[7]=1 SHALL enter state SHIFT_HI with bit count=0, including when a transfer is already in progress (restart).
REQ-017 A cpu_wr to FF02 with d_in[7]=0 during a transfer SHALL abort it:
- enter IDLE;
- sck_out=1;
- no int_serial pulse.
REQ-018 The state machine SHALL have states IDLE, SHIFT_HI and SHIFT_LO.
REQ-019 The serial edge source SHALL depend on clk_sel:
- clk_sel=1: each tick_8192hz is a serial edge, alternating falling/rising starting with falling.
- clk_sel=0: edges are falling/rising edges of sck_in after synchronisation.
REQ-020 A tick coinciding with the FF02 start write SHALL be ignored.
REQ-021 Falling edge (SHIFT_HI to SHIFT_LO):
- sout <= SB[7];
- sck_out <= 0 when clk_sel=1.
REQ-022 Rising edge (SHIFT_LO to SHIFT_HI):
- SB <= {SB[6:0], sin_sync};
- sck_out <= 1 when clk_sel=1;
- bit count increments by 1 (3-bit count, wraps 7 to 0).
REQ-023 On the rising edge that shifts the 8th bit, the block SHALL:
- clear start;
- enter IDLE;
- assert int_serial for exactly one clk1 cycle, on the cycle after that edge.
REQ-024 An internal-clock transfer SHALL take exactly 16 tick_8192hz pulses.
REQ-025 Edges in IDLE (start=0) SHALL be ignored; in external mode, edges SHALL shift only while start=1.
REQ-026 A cpu_wr to FF01 SHALL overwrite SB in any state. If it coincides with a shift, the written value wins and the bit count still advances; on the 8th bit, int_serial still fires.
REQ-027 sck_oe SHALL equal clk_sel; sck_out SHALL be 1 in IDLE.
REQ-028 sck_in and sin SHALL pass through a two-flop synchroniser; sck edges are detected from the synchronised value, adding 3 clk1 cycles of latency.

Reset
REQ-029 While nreset2=0, the block SHALL hold:
- SB=8'h00, start=0, clk_sel=0;
- state=IDLE, bit count=0;
- sck_out=1, sout=1, int_serial=0;
- synchroniser flops=1.
REQ-030 Reset mid-transfer SHALL abort the transfer immediately, with no int_serial pulse.

Structure
REQ-031 Package serial_pkg SHALL hold the state enum (IDLE, SHIFT_HI, SHIFT_LO) and the SC bit-position constants (SC_START=7, SC_CLKSEL=0).
REQ-032 The two-flop synchroniser SHALL be one reusable sub-module, sync2, instantiated for sck_in and for sin.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- Reset then read: read FF02 -> 8'h7E; read FF01 -> 8'h00; sck_out=1.
- Internal transfer: SB=8'hA5, sin=1, write FF02=8'h81, 16 ticks -> sout sequence 1,0,1,0,0,1,0,1; SB=8'hFF; int_serial high exactly 1 cycle; FF02 reads 8'h7F.
- External transfer: SB=8'h3C, FF02=8'h80, sin=0, drive 8 sck_in low/high pulses (each level held ≥4 clk1 cycles) -> SB=8'h00; int_serial 1 pulse; sck_oe=0 throughout.
- Abort: start internal transfer, after 6 ticks write FF02=8'h01 -> IDLE, sck_out=1; no int_serial over the next 20 ticks.
- Reset mid-transfer: assert nreset2=0 after 5 ticks -> all REQ-029 values at once; no int_serial.
- Collision: write FF01=8'h55 in the same cycle as the 8th rising edge -> SB=8'h55; int_serial still pulses once.
